// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W_DEF = $clog2(WIDTH_DEF + 1);

endpackage

// File: rtl/div_controller.sv
// IDLE/RUN/DONE sequencer for seq_divider; the datapath lives in the top.
module div_controller
    import seq_div_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic cnt_last_i,
    input  logic zero_div_i,
    output logic load_o,
    output logic step_o,
    output logic done_o,
    output logic busy_o,
    output logic ready_o
);

    state_e state_q, state_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // done_o strobes on the edge entering DONE so results are valid alongside ready.
    always_comb begin
        state_d = state_q;
        load_o  = 1'b0;
        step_o  = 1'b0;
        done_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    load_o = 1'b1;
                    if (zero_div_i) begin
                        state_d = DONE;
                        done_o  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                step_o = 1'b1;
                if (cnt_last_i) begin
                    state_d = DONE;
                    done_o  = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy_o  = (state_q == RUN);
    assign ready_o = (state_q == DONE);

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands (magnitude core + sign fix-up).
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ready,
    output logic             busy,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, quo_q, dvsr_q, quot_q, remd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dbz_q;
    logic             load, step, done, zero_div, cnt_last;
    logic [WIDTH-1:0] dvd_mag, dvs_mag, rem_nx, quo_nx, quot_res, remd_res;
    logic [WIDTH:0]   shifted, diff;
    logic             ge;

    assign zero_div = (divisor == '0);
    assign cnt_last = (cnt_q == CNT_W'(1));

    div_controller u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .cnt_last_i (cnt_last),
        .zero_div_i (zero_div),
        .load_o     (load),
        .step_o     (step),
        .done_o     (done),
        .busy_o     (busy),
        .ready_o    (ready)
    );

    // WIDTH+1-bit subtract: the borrow bit alone decides rem >= divisor.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvsr_q};
    assign ge      = ~diff[WIDTH];
    assign rem_nx  = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_nx  = {quo_q[WIDTH-2:0], ge};

`ifdef SEQ_DIV_SIGNED_EN
    logic qneg_q, rneg_q;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    assign dvd_mag  = mag(dividend);
    assign dvs_mag  = mag(divisor);
    assign quot_res = qneg_q ? -quo_nx : quo_nx;
    assign remd_res = rneg_q ? -rem_nx : rem_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else if (load) begin
            qneg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rneg_q <= dividend[WIDTH-1];
        end
    end
`else
    assign dvd_mag  = dividend;
    assign dvs_mag  = divisor;
    assign quot_res = quo_nx;
    assign remd_res = rem_nx;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
            quot_q <= '0;
            remd_q <= '0;
            dbz_q  <= 1'b0;
        end else if (load) begin
            rem_q  <= '0;
            quo_q  <= dvd_mag;
            dvsr_q <= dvs_mag;
            cnt_q  <= CNT_W'(WIDTH);
            dbz_q  <= zero_div;
            if (zero_div) begin
                quot_q <= '1;
                remd_q <= dividend;
            end
        end else if (step) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt_q <= cnt_q - CNT_W'(1);
            if (done) begin
                quot_q <= quot_res;
                remd_q <= remd_res;
            end
        end
    end

    assign quotient    = quot_q;
    assign remainder   = remd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider (WIDTH=16), unsigned or SEQ_DIV_SIGNED_EN build.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic [15:0] quotient, remainder;
    logic        ready, busy, div_by_zero;

    int total = 0;
    int bad = 0;

    seq_divider #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .ready       (ready),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Launch one division and watch cycles 1..24 after the accepting edge.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          output int rdy_cyc, output int rdy_cnt,
                          output logic [15:0] q, output logic [15:0] r, output logic z,
                          output logic z1, output logic busy1, output logic [15:0] q_end);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        rdy_cyc = -1;
        rdy_cnt = 0;
        q = 'x; r = 'x; z = 1'bx;
        z1 = 1'bx; busy1 = 1'bx;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 1) begin
                z1    = div_by_zero;
                busy1 = busy;
            end
            if (ready) begin
                rdy_cnt++;
                if (rdy_cyc < 0) begin
                    rdy_cyc = k;
                    q = quotient;
                    r = remainder;
                    z = div_by_zero;
                end
            end
        end
        q_end = quotient;
    endtask

    initial begin
        int          rc, rn;
        logic [15:0] q, r, qe;
        logic        z, z1, b1;
        int          seen;

`ifdef SEQ_DIV_SIGNED_EN
        vecs[0] = '{16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 1'b0};
        vecs[1] = '{16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0};
        vecs[2] = '{16'd100,  16'd7,    16'd14,   16'd2,    1'b0};
        vecs[3] = '{16'd100,  16'hFFF9, 16'hFFF2, 16'd2,    1'b0};
        vecs[4] = '{16'd1234, 16'd0,    16'hFFFF, 16'd1234, 1'b1};
        vecs[5] = '{16'hFFF9, 16'd0,    16'hFFFF, 16'hFFF9, 1'b1};
        vecs[6] = '{16'h8000, 16'd1,    16'h8000, 16'h0000, 1'b0};
        vecs[7] = '{16'hFF9C, 16'hFFF9, 16'd14,   16'hFFFE, 1'b0};
`else
        vecs[0] = '{16'd100,  16'd7,    16'd14,   16'd2,    1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0};
        vecs[2] = '{16'h0005, 16'hFFFF, 16'h0000, 16'h0005, 1'b0};
        vecs[3] = '{16'd1234, 16'd0,    16'hFFFF, 16'd1234, 1'b1};
        vecs[4] = '{16'd0,    16'd5,    16'd0,    16'd0,    1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 16'd1,    16'd0,    1'b0};
        vecs[6] = '{16'hFFFE, 16'h8001, 16'd1,    16'h7FFD, 1'b0};
        vecs[7] = '{16'd1000, 16'd33,   16'd30,   16'd10,   1'b0};
`endif

        // Reset state
        #12;
        check("rst_quotient", {16'h0, quotient}, 32'h0);
        check("rst_remainder", {16'h0, remainder}, 32'h0);
        check("rst_ready", {31'h0, ready}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_dbz", {31'h0, div_by_zero}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, rc, rn, q, r, z, z1, b1, qe);
            check($sformatf("v%0d_quotient", i), {16'h0, q}, {16'h0, vecs[i].q});
            check($sformatf("v%0d_remainder", i), {16'h0, r}, {16'h0, vecs[i].r});
            check($sformatf("v%0d_dbz", i), {31'h0, z}, {31'h0, vecs[i].z});
            check($sformatf("v%0d_ready_cycle", i), rc, vecs[i].z ? 1 : 17);
            check($sformatf("v%0d_ready_pulses", i), rn, 1);
            check($sformatf("v%0d_dbz_cycle1", i), {31'h0, z1}, {31'h0, vecs[i].z});
            check($sformatf("v%0d_busy_cycle1", i), {31'h0, b1}, {31'h0, ~vecs[i].z});
            check($sformatf("v%0d_hold", i), {16'h0, qe}, {16'h0, vecs[i].q});
        end

        // Extra start in the middle of RUN must be ignored
        @(negedge clk);
        dividend = 16'd100;
        divisor  = 16'd7;
        start    = 1'b1;
        @(posedge clk);
        rc = -1; rn = 0; q = 'x; r = 'x;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            start = (k == 5);
            if (k == 5) begin
                dividend = 16'd9;
                divisor  = 16'd3;
            end
            if (ready) begin
                rn++;
                if (rc < 0) begin
                    rc = k;
                    q = quotient;
                    r = remainder;
                end
            end
        end
        check("midrun_quotient", {16'h0, q}, 32'd14);
        check("midrun_remainder", {16'h0, r}, 32'd2);
        check("midrun_ready_cycle", rc, 17);
        check("midrun_ready_pulses", rn, 1);

        // Reset asserted in RUN cycle 8 of a second operation
        @(negedge clk);
        dividend = 16'd1000;
        divisor  = 16'd33;
        start    = 1'b1;
        @(posedge clk);
        seen = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (ready) seen++;
        end
        rst = 1'b0;
        #1;
        check("abort_quotient", {16'h0, quotient}, 32'h0);
        check("abort_remainder", {16'h0, remainder}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_ready", {31'h0, ready}, 32'h0);
        check("abort_dbz", {31'h0, div_by_zero}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (ready) seen++;
        end
        check("abort_no_ready", seen, 0);
        check("abort_quotient_held", {16'h0, quotient}, 32'h0);

        run_op(16'd1000, 16'd33, rc, rn, q, r, z, z1, b1, qe);
        check("post_rst_quotient", {16'h0, q}, 32'd30);
        check("post_rst_remainder", {16'h0, r}, 32'd10);
        check("post_rst_ready_cycle", rc, 17);
        check("post_rst_ready_pulses", rn, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
